// File: rtl/spill_rr_arbiter.sv
// Round-robin N:1 arbiter feeding a two-entry spill buffer (slot A = output, slot B = spill).
// Optional synchronous flush port is built when SPILL_RR_ARB_FLUSH_EN is defined.
module spill_rr_arbiter #(
  parameter int unsigned NumIn     = 4,
  parameter int unsigned DataWidth = 32,
  localparam int unsigned IdxWidth = $clog2(NumIn)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
`ifdef SPILL_RR_ARB_FLUSH_EN
  input  logic                       flush_i,
`endif
  input  logic [NumIn-1:0]           valid_i,
  output logic [NumIn-1:0]           ready_o,
  input  logic [NumIn*DataWidth-1:0] data_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [DataWidth-1:0]       data_o,
  output logic [IdxWidth-1:0]        idx_o
);

  logic flush;
`ifdef SPILL_RR_ARB_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  logic                 a_valid_q, a_valid_d;
  logic [DataWidth-1:0] a_data_q, a_data_d;
  logic [IdxWidth-1:0]  a_idx_q, a_idx_d;
  logic                 b_valid_q, b_valid_d;
  logic [DataWidth-1:0] b_data_q, b_data_d;
  logic [IdxWidth-1:0]  b_idx_q, b_idx_d;
  logic [IdxWidth-1:0]  ptr_q, ptr_d;

  logic [DataWidth-1:0] data_arr [NumIn];

  for (genvar g = 0; g < NumIn; g++) begin : g_unpack
    assign data_arr[g] = data_i[g*DataWidth +: DataWidth];
  end

  // Round-robin search starting at the pointer, wrapping past NumIn-1.
  logic                gnt_found;
  logic [IdxWidth-1:0] gnt_idx;
  int unsigned         cand;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int unsigned i = 0; i < NumIn; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= NumIn) begin
        cand = cand - NumIn;
      end
      if (!gnt_found && valid_i[IdxWidth'(cand)]) begin
        gnt_found = 1'b1;
        gnt_idx   = IdxWidth'(cand);
      end
    end
  end

  // Acceptance depends only on B occupancy, never on ready_i.
  always_comb begin
    ready_o = '0;
    if (gnt_found && !b_valid_q && !flush && rst_ni) begin
      ready_o[gnt_idx] = 1'b1;
    end
  end

  logic in_hs, out_hs;
  assign in_hs  = |ready_o;
  assign out_hs = a_valid_q & ready_i;

  always_comb begin
    a_valid_d = a_valid_q;
    a_data_d  = a_data_q;
    a_idx_d   = a_idx_q;
    b_valid_d = b_valid_q;
    b_data_d  = b_data_q;
    b_idx_d   = b_idx_q;
    ptr_d     = ptr_q;

    if (flush) begin
      a_valid_d = 1'b0;
      b_valid_d = 1'b0;
    end else begin
      if (out_hs) begin
        if (b_valid_q) begin
          a_valid_d = 1'b1;
          a_data_d  = b_data_q;
          a_idx_d   = b_idx_q;
          b_valid_d = 1'b0;
        end else if (in_hs) begin
          a_valid_d = 1'b1;
          a_data_d  = data_arr[gnt_idx];
          a_idx_d   = gnt_idx;
        end else begin
          a_valid_d = 1'b0;
        end
      end else if (in_hs) begin
        if (!a_valid_q) begin
          a_valid_d = 1'b1;
          a_data_d  = data_arr[gnt_idx];
          a_idx_d   = gnt_idx;
        end else begin
          b_valid_d = 1'b1;
          b_data_d  = data_arr[gnt_idx];
          b_idx_d   = gnt_idx;
        end
      end

      if (in_hs) begin
        ptr_d = (gnt_idx == IdxWidth'(NumIn - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_valid_q <= 1'b0;
      a_data_q  <= '0;
      a_idx_q   <= '0;
      b_valid_q <= 1'b0;
      b_data_q  <= '0;
      b_idx_q   <= '0;
      ptr_q     <= '0;
    end else begin
      a_valid_q <= a_valid_d;
      a_data_q  <= a_data_d;
      a_idx_q   <= a_idx_d;
      b_valid_q <= b_valid_d;
      b_data_q  <= b_data_d;
      b_idx_q   <= b_idx_d;
      ptr_q     <= ptr_d;
    end
  end

  assign valid_o = a_valid_q;
  assign data_o  = a_data_q;
  assign idx_o   = a_idx_q;

endmodule

// File: tb/tb_spill_rr_arbiter.sv
// Bench for spill_rr_arbiter: directed vector table, async-reset/flush sequences,
// then random traffic against a cycle-level queue model.
module tb_spill_rr_arbiter;

  localparam int unsigned NumIn = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned IW    = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush_v;
  logic [3:0]      valid_i;
  logic [3:0]      ready_o;
  logic [127:0]    data_i;
  logic            valid_o;
  logic            ready_i;
  logic [DW-1:0]   data_o;
  logic [IW-1:0]   idx_o;

  always #5 clk = ~clk;

  spill_rr_arbiter #(
    .NumIn    (NumIn),
    .DataWidth(DW)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
`ifdef SPILL_RR_ARB_FLUSH_EN
    .flush_i(flush_v),
`endif
    .valid_i(valid_i),
    .ready_o(ready_o),
    .data_i (data_i),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .data_o (data_o),
    .idx_o  (idx_o)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [IW-1:0] idx;
  } beat_t;

  typedef struct {
    logic [3:0]    v;
    logic          rdy;
    logic [DW-1:0] d2;
    logic [3:0]    er;
    logic          ev;
    logic [IW-1:0] ei;
    logic [DW-1:0] ed;
  } vec_t;

  beat_t q[$];
  vec_t  tbl[21];
  int    n_chk = 0;
  int    n_pass = 0;
  int    m_ptr = 0;
  int    m_gidx = 0;
  logic  m_in_hs, m_out_hs;
  beat_t m_new;
  int    wait_cnt[4];
  int    max_wait = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [3:0] model_grant(input logic [3:0] v, input int p, output int gi);
    int k;
    model_grant = '0;
    gi = -1;
    for (int i = 0; i < 4; i++) begin
      k = (p + i) % 4;
      if (gi < 0 && v[k]) begin
        gi = k;
        model_grant[k] = 1'b1;
      end
    end
  endfunction

  task automatic set_data(input logic [DW-1:0] d2);
    for (int k = 0; k < 4; k++) data_i[k*32 +: 32] = 32'hD000_0000 + k;
    data_i[64 +: 32] = d2;
  endtask

  // Compare outputs against the model at the falling edge and record the expected handshakes.
  task automatic sample();
    logic [3:0] er;
    int gi;
    @(negedge clk);
    er = model_grant(valid_i, m_ptr, gi);
    if (!rst_n || q.size() == 2 || flush_v) er = '0;
    chk("ready_o", ready_o, er);
    chk("valid_o", valid_o, q.size() > 0);
    if (q.size() > 0) begin
      chk("data_o", data_o, q[0].data);
      chk("idx_o", idx_o, q[0].idx);
    end
    m_out_hs = rst_n && !flush_v && q.size() > 0 && ready_i;
    m_in_hs  = er != 0;
    if (m_in_hs) begin
      m_gidx = gi;
      m_new  = '{data: data_i[gi*32 +: 32], idx: gi[1:0]};
    end
    for (int k = 0; k < 4; k++) begin
      if (!valid_i[k] || (m_in_hs && k == gi)) wait_cnt[k] = 0;
      else if (m_in_hs) begin
        wait_cnt[k]++;
        if (wait_cnt[k] > max_wait) max_wait = wait_cnt[k];
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    if (!rst_n) begin
      q.delete();
      m_ptr = 0;
    end else if (flush_v) begin
      q.delete();
    end else begin
      if (m_out_hs) void'(q.pop_front());
      if (m_in_hs) begin
        q.push_back(m_new);
        m_ptr = (m_gidx + 1) % 4;
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) wait_cnt[k] = 0;
    //            v      rdy   d2            er      ev    ei     ed
    tbl[0]  = '{4'hF, 1'b1, 32'hD000_0002, 4'b0001, 1'b0, 2'd0, 32'h0};
    tbl[1]  = '{4'hF, 1'b1, 32'hD000_0002, 4'b0010, 1'b1, 2'd0, 32'hD000_0000};
    tbl[2]  = '{4'hF, 1'b1, 32'hD000_0002, 4'b0100, 1'b1, 2'd1, 32'hD000_0001};
    tbl[3]  = '{4'hF, 1'b1, 32'hD000_0002, 4'b1000, 1'b1, 2'd2, 32'hD000_0002};
    tbl[4]  = '{4'hF, 1'b1, 32'hD000_0002, 4'b0001, 1'b1, 2'd3, 32'hD000_0003};
    tbl[5]  = '{4'hF, 1'b1, 32'hD000_0002, 4'b0010, 1'b1, 2'd0, 32'hD000_0000};
    tbl[6]  = '{4'hF, 1'b1, 32'hD000_0002, 4'b0100, 1'b1, 2'd1, 32'hD000_0001};
    tbl[7]  = '{4'hF, 1'b1, 32'hD000_0002, 4'b1000, 1'b1, 2'd2, 32'hD000_0002};
    tbl[8]  = '{4'h0, 1'b1, 32'hD000_0002, 4'b0000, 1'b1, 2'd3, 32'hD000_0003};
    tbl[9]  = '{4'h0, 1'b1, 32'hD000_0002, 4'b0000, 1'b0, 2'd0, 32'h0};
    tbl[10] = '{4'h4, 1'b0, 32'h0000_00A5, 4'b0100, 1'b0, 2'd0, 32'h0};
    tbl[11] = '{4'h4, 1'b0, 32'h0000_00B6, 4'b0100, 1'b1, 2'd2, 32'h0000_00A5};
    tbl[12] = '{4'h4, 1'b0, 32'h0000_00C7, 4'b0000, 1'b1, 2'd2, 32'h0000_00A5};
    tbl[13] = '{4'h0, 1'b1, 32'hD000_0002, 4'b0000, 1'b1, 2'd2, 32'h0000_00A5};
    tbl[14] = '{4'h0, 1'b1, 32'hD000_0002, 4'b0000, 1'b1, 2'd2, 32'h0000_00B6};
    tbl[15] = '{4'h0, 1'b1, 32'hD000_0002, 4'b0000, 1'b0, 2'd0, 32'h0};
    tbl[16] = '{4'h1, 1'b1, 32'hD000_0002, 4'b0001, 1'b0, 2'd0, 32'h0};
    tbl[17] = '{4'h1, 1'b1, 32'hD000_0002, 4'b0001, 1'b1, 2'd0, 32'hD000_0000};
    tbl[18] = '{4'h3, 1'b1, 32'hD000_0002, 4'b0010, 1'b1, 2'd0, 32'hD000_0000};
    tbl[19] = '{4'h0, 1'b1, 32'hD000_0002, 4'b0000, 1'b1, 2'd1, 32'hD000_0001};
    tbl[20] = '{4'h0, 1'b1, 32'hD000_0002, 4'b0000, 1'b0, 2'd0, 32'h0};

    // Reset state, with requests pending.
    rst_n   = 1'b0;
    flush_v = 1'b0;
    valid_i = 4'hF;
    ready_i = 1'b1;
    set_data(32'hD000_0002);
    sample();
    chk("rst_data_o", data_o, 0);
    chk("rst_idx_o", idx_o, 0);
    advance();
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      valid_i = tbl[i].v;
      ready_i = tbl[i].rdy;
      set_data(tbl[i].d2);
      sample();
      chk($sformatf("row%0d_ready", i), ready_o, tbl[i].er);
      chk($sformatf("row%0d_valid", i), valid_o, tbl[i].ev);
      if (tbl[i].ev) begin
        chk($sformatf("row%0d_idx", i), idx_o, tbl[i].ei);
        chk($sformatf("row%0d_data", i), data_o, tbl[i].ed);
      end
      advance();
    end

    // Fill both slots, then reset asynchronously between edges.
    valid_i = 4'hF;
    ready_i = 1'b0;
    repeat (2) begin
      sample();
      advance();
    end
    valid_i = 4'h0;
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", valid_o, 0);
    chk("async_rst_ready", ready_o, 0);
    q.delete();
    m_ptr = 0;
    #1 rst_n = 1'b1;
    valid_i = 4'b1010;
    ready_i = 1'b1;
    sample();
    chk("post_rst_grant", ready_o, 4'b0010);
    advance();
    valid_i = 4'h0;
    repeat (3) begin
      sample();
      advance();
    end

`ifdef SPILL_RR_ARB_FLUSH_EN
    valid_i = 4'hF;
    ready_i = 1'b0;
    repeat (2) begin
      sample();
      advance();
    end
    flush_v = 1'b1;
    sample();
    chk("flush_ready", ready_o, 0);
    advance();
    flush_v = 1'b0;
    valid_i = 4'h0;
    ready_i = 1'b1;
    sample();
    chk("flush_valid", valid_o, 0);
    advance();
    repeat (3) begin
      sample();
      advance();
    end
`endif

    // Random traffic.
    for (int c = 0; c < 10000; c++) begin
      valid_i = 4'($urandom_range(0, 15));
      ready_i = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 4; k++) data_i[k*32 +: 32] = $urandom();
`ifdef SPILL_RR_ARB_FLUSH_EN
      flush_v = ($urandom_range(0, 63) == 0);
`endif
      sample();
      advance();
    end
    flush_v = 1'b0;
    valid_i = 4'h0;
    ready_i = 1'b1;
    repeat (4) begin
      sample();
      advance();
    end
    chk("fair_wait_bound", max_wait <= NumIn, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/spill_rr_arbiter.md
SPILL_RR_ARBITER -- requirements
Module: spill_rr_arbiter

Interface
REQ-001: Parameter NumIn, default 4: number of requesters; legal range 2..16.
REQ-002: Parameter DataWidth, default 32: payload width in bits.
REQ-003: Local parameter IdxWidth SHALL be $clog2(NumIn).
REQ-004: clk_i  input  1  clock; all state updates on rising edge.
REQ-005: rst_ni  input  1  reset, asynchronous, active-low.
REQ-006: flush_i  input  1  drop buffered beats; port present only with SPILL_RR_ARB_FLUSH_EN defined.
REQ-007: valid_i  input  NumIn  per-requester valid.
REQ-008: ready_o  output  NumIn  per-requester ready; one-hot or zero.
REQ-009: data_i  input  NumIn*DataWidth  payloads; requester k occupies bits [k*DataWidth +: DataWidth].
REQ-010: valid_o  output  1  output beat valid.
REQ-011: ready_i  input  1  downstream ready.
REQ-012: data_o  output  DataWidth  output payload.
REQ-013: idx_o  output  IdxWidth  index of the requester that sourced data_o.

Function
REQ-014: Two-entry buffer SHALL be used: slot A drives valid_o/data_o/idx_o; slot B holds a spilled beat when A is stalled.
REQ-015: ready_o and valid_o SHALL depend only on registered state, valid_i and the RR pointer; no combinational path ready_i->ready_o or valid_i->valid_o.
REQ-016: Input accept condition: slot B empty; the granted requester sees ready_o[k]=1 and all others see 0.
REQ-017: Grant is round-robin: first k with valid_i[k]=1, searching from pointer upward and wrapping from NumIn-1 to 0.
REQ-018: Pointer SHALL update to (granted k + 1) mod NumIn only on an input handshake, and is unchanged otherwise.
REQ-019: A beat accepted while A is empty, or while A drains in the same cycle (valid_o & ready_i) with B empty, SHALL load into A; otherwise it loads into B.
REQ-020: On output handshake with B full, B SHALL move to A in the same edge, and B becomes empty.
REQ-021: Latency SHALL be 1 cycle from input handshake to valid_o; sustained throughput SHALL be 1 beat/cycle while ready_i=1.
REQ-022: Output order SHALL equal acceptance order; no beat is dropped or duplicated except by flush.
REQ-023: A requester that deasserts valid_i without a handshake SHALL lose its grant with no side effects.
REQ-024: With all valid_i=0, all ready_o SHALL be 0 and the pointer SHALL hold.

Reset
REQ-025: While rst_ni=0: A and B empty, valid_o=0, ready_o=0, data_o=0, idx_o=0, pointer=0.
REQ-026: Reset assertion mid-transfer SHALL discard both slots immediately and asynchronously, with no output beat completing.
REQ-027: After release, the first grant SHALL go to the lowest-index valid requester.

Configuration
REQ-028: Macro SPILL_RR_ARB_FLUSH_EN defined: flush_i present; flush_i=1 at an edge SHALL empty A and B, force ready_o=0 in that cycle, and leave the pointer unchanged.
REQ-029: Macro SPILL_RR_ARB_FLUSH_EN undefined: flush_i absent and behaviour identical to flush permanently 0.

Verification
REQ-030: Reset, then valid_i=4'b1111 and ready_i=1 for 8 cycles -> idx_o sequence 0,1,2,3,0,1,2,3 and valid_o=1 from cycle 1 on.
REQ-031: ready_i=0, valid_i[2]=1 with data 0xA5, then 0xB6 -> both accepted; ready_o=0 on the 3rd cycle; ready_i=1 -> 0xA5 then 0xB6 out.
REQ-032: Pointer=1, valid_i=4'b0001 -> requester 0 granted via wrap; pointer becomes 1.
REQ-033: Random valid_i/ready_i for 10k cycles -> scoreboard order match, no loss or duplication, and no requester waits more than NumIn grants.
REQ-034: With the macro defined, fill both slots, then pulse flush_i -> valid_o=0 next cycle and no flushed data appears.
REQ-035: Assert rst_ni=0 with both slots full -> valid_o=0 asynchronously; after release, the first grant goes to the lowest-index valid requester.
